dmem_imem_arbiter: RTL
======================

DMEM_IMEM_ARBITER -- requirements
Module: dmem_imem_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 32, data/address width in bits.
REQ-002 SHALL have port: clk  input  1  clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: imem_addr input 32, imem_rmask input 4: instruction request, sampled when rmask is nonzero.
REQ-005 SHALL have ports: imem_rdata output 32, imem_resp output 1: instruction response.
REQ-006 SHALL have ports: dmem_addr input 32, dmem_rmask input 4, dmem_wmask input 4, dmem_wdata input 32: data request, sampled when either mask is nonzero.
REQ-007 SHALL have ports: dmem_rdata output 32, dmem_resp output 1: data response.
REQ-008 SHALL have ports: mem_addr output 32, mem_rmask output 4, mem_wmask output 4, mem_wdata output 32: shared downstream request.
REQ-009 SHALL have ports: mem_rdata input 32, mem_resp input 1: shared downstream response.

Function
REQ-010 SHALL treat a request as a one-cycle nonzero mask, after which the requester waits for its resp; one outstanding request per requester.
REQ-011 SHALL capture each request (addr, masks, wdata) into a per-requester pending register in its request cycle.
REQ-012 SHALL implement the states IDLE, BUSY_I and BUSY_D.
REQ-013 SHALL make a grant decision in any cycle that is IDLE or BUSY_x with mem_resp=1, considering pending registers OR new requests in that cycle.
REQ-014 On grant, SHALL enter BUSY_I/BUSY_D and drive the granted masks on mem_* (registered) for exactly the first cycle of BUSY_x; masks SHALL be 0 otherwise.
REQ-015 SHALL hold mem_addr/mem_wdata stable for the whole BUSY_x.
REQ-016 Latency: request in cycle N while IDLE -> mem mask in N+1; mem_resp in M -> owner resp in M (combinational), with the next grant's mask in M+1 (back-to-back).
REQ-017 SHALL forward mem_rdata to both imem_rdata and dmem_rdata; only the owner's resp SHALL assert.
REQ-018 SHALL clear the owner's pending entry on mem_resp and return to IDLE if nothing is pending.
REQ-019 On a simultaneous conflict, SHALL use the priority defined in REQ-025/REQ-026.
REQ-020 SHALL ignore mem_resp while IDLE (no resp forwarded).
REQ-021 SHALL ignore a new request from a requester that already has a pending or outstanding request; simulation assertion SHALL fire.

Reset
REQ-022 On rst, SHALL go to IDLE, clear pending entries, and clear the round-robin pointer to "last=imem".
REQ-023 SHALL reset outputs: mem_rmask=0, mem_wmask=0, mem_addr=0, mem_wdata=0, imem_resp=0, dmem_resp=0.
REQ-024 Reset mid-operation SHALL drop the outstanding request silently; a late mem_resp is covered by REQ-020.

Configuration
REQ-025 With ARB_ROUND_ROBIN_EN defined, on conflict SHALL grant the requester not granted last.
REQ-026 Without ARB_ROUND_ROBIN_EN, SHALL give dmem fixed priority over imem.

Structure
REQ-027 The shared rv32imc_types package SHALL hold arb_state_t (IDLE/BUSY_I/BUSY_D) and mem_req_t (addr, rmask, wmask, wdata).
REQ-028 SHALL instantiate sub-module arb_req_slot twice (capture, hold and clear of one pending request).

Verification
REQ-029 imem rmask=4'hF at addr 0x6000_0000 in cycle 0 while IDLE -> mem_rmask=4'hF, mem_addr=0x6000_0000 in cycle 1; mem_resp with rdata 0x0000_0013 -> imem_resp=1, imem_rdata=0x0000_0013, dmem_resp=0.
REQ-030 imem and dmem (wmask=4'h3, addr 0x1000_0004, wdata 0xBEEF) in the same cycle, fixed priority -> dmem issued first; imem issued the cycle after the dmem mem_resp.
REQ-031 Same stimulus with ARB_ROUND_ROBIN_EN and last=dmem -> imem issued first; a repeated conflict after both complete -> dmem issued first.
REQ-032 dmem request arrives during BUSY_I -> pending; issued in the cycle after the imem mem_resp, with mem_addr held for the entire prior BUSY_I.
REQ-033 rst asserted in BUSY_D, then mem_resp=1 two cycles later -> state IDLE, dmem_resp=0, all masks 0.

Source files
------------

// File: rtl/rv32imc_types.sv
// Shared types for the instruction/data memory arbiter: arbiter states and
// the downstream memory request payload.
package rv32imc_types;

  localparam int unsigned MEM_W  = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [MEM_W-1:0]  addr;
    logic [MASK_W-1:0] rmask;
    logic [MASK_W-1:0] wmask;
    logic [MEM_W-1:0]  wdata;
  } mem_req_t;

  // A request is live in the cycle either of its byte masks is nonzero
  function automatic logic req_active(input mem_req_t r);
    return (r.rmask != '0) || (r.wmask != '0);
  endfunction

endpackage

// File: rtl/arb_req_slot.sv
// One requester's pending-request register: captures a request in its
// request cycle, holds it while it waits and while it is outstanding
// downstream, and drops it when the downstream response arrives.
module arb_req_slot
  import rv32imc_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     capture,
  input  logic     clear,
  input  mem_req_t req_in,
  output logic     valid,
  output mem_req_t req
);

  // Capture, hold and clear of the single pending entry
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      req   <= req_in;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmem_imem_arbiter.sv
// Arbitrates the instruction and data ports of the core onto one shared
// memory port. One request per requester may be in flight; a request is a
// one-cycle nonzero mask and is answered by a one-cycle resp.
// Build option: ARB_ROUND_ROBIN_EN selects alternating priority on a
// contested decision; otherwise dmem always wins a conflict.
module dmem_imem_arbiter
  import rv32imc_types::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] imem_addr,
  input  logic [MASK_W-1:0] imem_rmask,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic [DATA_W-1:0] dmem_addr,
  input  logic [MASK_W-1:0] dmem_rmask,
  input  logic [MASK_W-1:0] dmem_wmask,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic [DATA_W-1:0] mem_addr,
  output logic [MASK_W-1:0] mem_rmask,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t state;
  arb_state_t state_next;

  mem_req_t imem_in;
  mem_req_t dmem_in;
  mem_req_t imem_slot_req;
  mem_req_t dmem_slot_req;
  mem_req_t imem_eff;
  mem_req_t dmem_eff;
  mem_req_t grant_req;

  logic imem_slot_valid;
  logic dmem_slot_valid;
  logic imem_new;
  logic dmem_new;
  logic imem_cand;
  logic dmem_cand;
  logic decide;
  logic grant_i;
  logic grant_d;
  logic prefer_dmem;

  // Pack the raw port requests into the shared payload format
  always_comb begin
    imem_in       = '0;
    imem_in.addr  = MEM_W'(imem_addr);
    imem_in.rmask = imem_rmask;
    dmem_in       = '0;
    dmem_in.addr  = MEM_W'(dmem_addr);
    dmem_in.rmask = dmem_rmask;
    dmem_in.wmask = dmem_wmask;
    dmem_in.wdata = MEM_W'(dmem_wdata);
  end

  // A new request is accepted only when its requester has nothing held
  assign imem_new = req_active(imem_in) && !imem_slot_valid;
  assign dmem_new = req_active(dmem_in) && !dmem_slot_valid;

  // A held request takes precedence; otherwise forward this cycle's request
  assign imem_eff = imem_slot_valid ? imem_slot_req : imem_in;
  assign dmem_eff = dmem_slot_valid ? dmem_slot_req : dmem_in;

  arb_req_slot u_imem_slot (
    .clk     (clk),
    .rst     (rst),
    .capture (imem_new),
    .clear   (imem_resp),
    .req_in  (imem_in),
    .valid   (imem_slot_valid),
    .req     (imem_slot_req)
  );

  arb_req_slot u_dmem_slot (
    .clk     (clk),
    .rst     (rst),
    .capture (dmem_new),
    .clear   (dmem_resp),
    .req_in  (dmem_in),
    .valid   (dmem_slot_valid),
    .req     (dmem_slot_req)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_imem;

  // Remember the winner of the most recent contested decision
  always_ff @(posedge clk) begin
    if (rst) begin
      last_imem <= 1'b1;
    end else if (decide && imem_cand && dmem_cand) begin
      last_imem <= grant_i;
    end
  end

  assign prefer_dmem = last_imem;
`else
  assign prefer_dmem = 1'b1;
`endif

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: re-arbitrate whenever the shared port is free or just freed
  always_comb begin
    state_next = state;
    if (decide) begin
      if (grant_d) begin
        state_next = BUSY_D;
      end else if (grant_i) begin
        state_next = BUSY_I;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Grant selection and combinational response steering to the owner
  always_comb begin
    decide    = 1'b0;
    imem_cand = 1'b0;
    dmem_cand = 1'b0;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    grant_req = '0;
    imem_resp = 1'b0;
    dmem_resp = 1'b0;

    decide    = (state == IDLE) || mem_resp;
    // The owner's own entry is excluded: it is the one completing now
    imem_cand = (imem_slot_valid && (state != BUSY_I)) || imem_new;
    dmem_cand = (dmem_slot_valid && (state != BUSY_D)) || dmem_new;
    grant_d   = decide && dmem_cand && (!imem_cand || prefer_dmem);
    grant_i   = decide && imem_cand && !grant_d;
    grant_req = grant_d ? dmem_eff : imem_eff;

    // A response seen while idle or in reset belongs to nobody
    imem_resp = !rst && (state == BUSY_I) && mem_resp;
    dmem_resp = !rst && (state == BUSY_D) && mem_resp;
  end

  // Downstream request: masks pulse for one cycle, addr/wdata held until next grant
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_rmask <= '0;
      mem_wmask <= '0;
      mem_wdata <= '0;
    end else if (grant_i || grant_d) begin
      mem_addr  <= DATA_W'(grant_req.addr);
      mem_rmask <= grant_req.rmask;
      mem_wmask <= grant_req.wmask;
      mem_wdata <= DATA_W'(grant_req.wdata);
    end else begin
      mem_rmask <= '0;
      mem_wmask <= '0;
    end
  end

  // Read data is shared; only the resp strobe identifies the recipient
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

  // A requester must not issue again while its previous request is held
  a_imem_single: assert property (@(posedge clk) disable iff (rst)
    !((imem_rmask != '0) && imem_slot_valid));

  a_dmem_single: assert property (@(posedge clk) disable iff (rst)
    !(((dmem_rmask | dmem_wmask) != '0) && dmem_slot_valid));

  // While busy, the owner's entry must still be held
  a_owner_held: assert property (@(posedge clk) disable iff (rst)
    ((state != BUSY_I) || imem_slot_valid) && ((state != BUSY_D) || dmem_slot_valid));

endmodule
